stereo_audio_deserializer: RTL and testbench
============================================

# stereo_audio_deserializer

Collects a time-multiplexed mono sample stream tagged with a left/right flag and reassembles it into parallel stereo pairs. It sits downstream of serialized per-channel processing, such as a shared echo datapath, and rebuilds the left/right pair for the stereo output stage. Both sides use valid/ready handshakes. The block detects channel misalignment and resynchronises on it.

## Interface
- audio_width, default 32: bits per channel sample.
- err_count_width, default 16: width of the sync-error counter (used only with the macro).

- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  serial sample valid.
- i_ready  output  1  block accepts serial sample.
- i_is_left  input  1  1 = sample is the left channel, 0 = right channel.
- i_audio  input  audio_width  serial sample.
- o_valid  output  1  stereo pair valid.
- o_ready  input  1  consumer accepts pair.
- o_left  output  audio_width  left sample of the pair.
- o_right  output  audio_width  right sample of the pair.
- o_sync_error  output  1  one-cycle pulse on each misaligned sample accepted.
- o_error_count  output  err_count_width  saturating misalignment count (only with the macro).

## Operation
- Input transfer occurs when i_valid && i_ready. Output transfer occurs when o_valid && o_ready.
- State machine has two states, WAIT_LEFT (reset state) and WAIT_RIGHT.
- WAIT_LEFT, left sample accepted: store it in the staging register, go to WAIT_RIGHT.
- WAIT_LEFT, right sample accepted: discard it, pulse o_sync_error, stay in WAIT_LEFT.
- WAIT_RIGHT, right sample accepted:
  - Load the output register: o_left <= staging, o_right <= i_audio.
  - Set o_valid <= 1, go to WAIT_LEFT.
- WAIT_RIGHT, left sample accepted: overwrite staging with the new left, pulse o_sync_error, stay in WAIT_RIGHT. The newest left wins.
- i_ready = (state == WAIT_LEFT) || !o_valid || o_ready.
  - Purely a function of registered state and o_ready; never depends on i_valid, i_is_left or i_audio.
- o_valid clears after an output transfer unless a new pair loads in the same cycle.
- o_left and o_right hold stable while o_valid && !o_ready.
- Reset values:
  - o_valid = 0, o_sync_error = 0.
  - o_left = o_right = 0, staging = 0.
  - state = WAIT_LEFT, o_error_count = 0.
- Reset mid-pair discards the staged left. The next accepted sample must be a left.

## Timing
- Latency: a right sample accepted at edge N makes its pair visible with o_valid = 1 after edge N.
- Full throughput: one serial sample per cycle, one pair per two cycles, when o_ready is held high.
- Simultaneous right accept and output transfer in the same cycle: the new pair replaces the old one and o_valid stays 1, with no bubble.
- Output stalled (o_valid && !o_ready):
  - One further left is still accepted into staging.
  - In WAIT_RIGHT, i_ready = 0 until the pair drains.
- o_sync_error is registered and asserts in the cycle after the offending accept.

## Configuration
- STEREO_AUDIO_DESERIALIZER_ERRCNT_EN defined:
  - Port o_error_count exists.
  - It increments on every o_sync_error event and saturates at all-ones.
  - It is cleared only by reset.
- Macro undefined: port and counter are absent. All other behaviour is identical, including o_sync_error.

## Structure
- Shared package stereo_audio_pkg holds:
  - the state encoding (WAIT_LEFT = 1'b0, WAIT_RIGHT = 1'b1);
  - the default audio width constant.
- One sub-module is natural: saturating_counter (parameter width; inputs clk, reset, inc; output count). It is instantiated only under the macro.

## Test plan
- Reset, then L = 0x11111111, R = 0x22222222 back to back with o_ready = 1:
  - o_valid pulses once the cycle after R is accepted;
  - o_left = 0x11111111, o_right = 0x22222222.
- Four stereo pairs streamed continuously with o_ready = 1: i_ready is never 0 and four pairs emerge in order.
- o_ready = 0 after the first pair:
  - the next L is accepted, the next R stalls (i_ready = 0);
  - the first pair stays unchanged;
  - releasing o_ready yields the second pair the cycle after R is accepted.
- Stream R, L = 0xA, L = 0xB, R = 0xC:
  - two o_sync_error pulses;
  - a single pair with left = 0xB, right = 0xC.
- Assert reset after L is accepted, then send R, L = 0x5, R = 0x6:
  - the R is discarded with o_sync_error;
  - the pair output is (0x5, 0x6).
- With STEREO_AUDIO_DESERIALIZER_ERRCNT_EN and err_count_width = 2, send five misaligned rights: o_error_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/stereo_audio_pkg.sv
// ---------------------------------------------------------------------------
// stereo_audio_pkg
//   Shared definitions for the stereo audio deserializer:
//     - state_e             : pairing state (waiting for left / waiting for right)
//     - AUDIO_WIDTH_DEFAULT : default bits per channel sample
// ---------------------------------------------------------------------------
package stereo_audio_pkg;

  localparam int AUDIO_WIDTH_DEFAULT = 32;

  typedef enum logic {
    WAIT_LEFT  = 1'b0,
    WAIT_RIGHT = 1'b1
  } state_e;

endpackage

// File: rtl/stereo_audio_deserializer_saturating_counter.sv
// ---------------------------------------------------------------------------
// saturating_counter
//   Up-counter that sticks at all-ones. It is cleared only by reset.
//   Ports:
//     clk   in  clock
//     reset in  asynchronous active-high reset
//     inc   in  count one event this cycle
//     count out current count value
// ---------------------------------------------------------------------------
module saturating_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [width-1:0] count
);

  logic [width-1:0] count_q;
  logic [width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stereo_audio_deserializer.sv
// ---------------------------------------------------------------------------
// stereo_audio_deserializer
//   Rebuilds left/right stereo pairs from a time-multiplexed mono stream
//   tagged with a left/right flag. Misaligned samples (a right with no
//   pending left, or a second left before its right) raise a one-cycle
//   o_sync_error pulse; the pairing resynchronises on the next left.
//
//   Optional feature: define STEREO_AUDIO_DESERIALIZER_ERRCNT_EN to add the
//   o_error_count port, a saturating count of o_sync_error pulses.
//
//   Ports:
//     clk, reset    clock, asynchronous active-high reset
//     i_valid       serial sample valid
//     i_ready       block accepts a serial sample
//     i_is_left     1 = left sample, 0 = right sample
//     i_audio       serial sample
//     o_valid       stereo pair valid
//     o_ready       consumer accepts the pair
//     o_left        left sample of the pair
//     o_right       right sample of the pair
//     o_sync_error  one-cycle pulse per misaligned sample accepted
//     o_error_count saturating misalignment count (macro only)
// ---------------------------------------------------------------------------
module stereo_audio_deserializer
  import stereo_audio_pkg::*;
#(
  parameter int audio_width     = AUDIO_WIDTH_DEFAULT,
  parameter int err_count_width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic                   i_is_left,
  input  logic [audio_width-1:0] i_audio,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [audio_width-1:0] o_left,
  output logic [audio_width-1:0] o_right,
  output logic                   o_sync_error
`ifdef STEREO_AUDIO_DESERIALIZER_ERRCNT_EN
  ,
  output logic [err_count_width-1:0] o_error_count
`endif
);

  state_e                 state_q,    state_d;
  logic [audio_width-1:0] staging_q,  staging_d;
  logic [audio_width-1:0] left_q,     left_d;
  logic [audio_width-1:0] right_q,    right_d;
  logic                   valid_q,    valid_d;
  logic                   sync_err_q, sync_err_d;
  logic                   in_fire;

  // A left can always be staged; a right may only complete a pair when the
  // output register is free or draining this very cycle.
  assign i_ready = (state_q == WAIT_LEFT) || !valid_q || o_ready;
  assign in_fire = i_valid && i_ready;

  always_comb begin
    state_d    = state_q;
    staging_d  = staging_q;
    left_d     = left_q;
    right_d    = right_q;
    valid_d    = valid_q;
    sync_err_d = 1'b0;

    if (valid_q && o_ready) begin
      valid_d = 1'b0;
    end

    if (in_fire) begin
      case (state_q)
        WAIT_LEFT: begin
          if (i_is_left) begin
            staging_d = i_audio;
            state_d   = WAIT_RIGHT;
          end else begin
            // Orphan right: dropped.
            sync_err_d = 1'b1;
          end
        end
        WAIT_RIGHT: begin
          if (!i_is_left) begin
            // Loading here overrides the drain-clear above, so a pair that
            // completes while the previous one drains causes no bubble.
            left_d  = staging_q;
            right_d = i_audio;
            valid_d = 1'b1;
            state_d = WAIT_LEFT;
          end else begin
            // Repeated left: the newest left replaces the staged one.
            staging_d  = i_audio;
            sync_err_d = 1'b1;
          end
        end
        default: state_d = WAIT_LEFT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_LEFT;
      staging_q  <= '0;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      staging_q  <= staging_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_left       = left_q;
  assign o_right      = right_q;
  assign o_sync_error = sync_err_q;

`ifdef STEREO_AUDIO_DESERIALIZER_ERRCNT_EN
  saturating_counter #(
    .width(err_count_width)
  ) u_err_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (sync_err_q),
    .count(o_error_count)
  );
`endif

endmodule

// File: tb/tb_stereo_audio_deserializer.sv
// ---------------------------------------------------------------------------
// tb_stereo_audio_deserializer
//   Self-checking bench. Expected pairs are queued as stimulus is driven and
//   compared when the DUT hands a pair over (o_valid && o_ready).
// ---------------------------------------------------------------------------
module tb_stereo_audio_deserializer;

  localparam int AW = 32;
`ifdef STEREO_AUDIO_DESERIALIZER_ERRCNT_EN
  localparam int EW = 2;
`else
  localparam int EW = 16;
`endif

  typedef struct packed {
    logic [AW-1:0] l;
    logic [AW-1:0] r;
  } pair_t;

  logic          clk;
  logic          reset;
  logic          i_valid;
  logic          i_ready;
  logic          i_is_left;
  logic [AW-1:0] i_audio;
  logic          o_valid;
  logic          o_ready;
  logic [AW-1:0] o_left;
  logic [AW-1:0] o_right;
  logic          o_sync_error;
`ifdef STEREO_AUDIO_DESERIALIZER_ERRCNT_EN
  logic [EW-1:0] o_error_count;
`endif

  stereo_audio_deserializer #(
    .audio_width    (AW),
    .err_count_width(EW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .i_is_left   (i_is_left),
    .i_audio     (i_audio),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_left      (o_left),
    .o_right     (o_right),
    .o_sync_error(o_sync_error)
`ifdef STEREO_AUDIO_DESERIALIZER_ERRCNT_EN
    ,
    .o_error_count(o_error_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pair_t exp_q[$];
  int    checks       = 0;
  int    errors       = 0;
  int    sync_seen    = 0;
  int    valid_cycles = 0;
  int    ready_low    = 0;
  bit    watch_ready  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    pair_t e;
    if (!reset) begin
      if (o_sync_error) sync_seen++;
      if (o_valid) valid_cycles++;
      if (watch_ready && i_valid && !i_ready) ready_low++;
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pair", {o_left, o_right}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          $display("pair L=%08h R=%08h (expected L=%08h R=%08h)", o_left, o_right, e.l, e.r);
          check("pair", {o_left, o_right}, e);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic l, input logic [AW-1:0] d);
    bit ok;
    ok        = 0;
    i_valid   = 1'b1;
    i_is_left = l;
    i_audio   = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      ok = i_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    i_valid   = 1'b0;
    i_is_left = 1'b0;
    i_audio   = '0;
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      wait_cycles(1);
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic push(input logic [AW-1:0] l, input logic [AW-1:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    exp_q.push_back(p);
  endtask

  initial begin
    int v0;
    int s0;
    int exp_cnt;

    reset   = 1'b1;
    o_ready = 1'b1;
    idle();
    wait_cycles(3);
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_left", 64'(o_left), 64'd0);
    check("rst_o_right", 64'(o_right), 64'd0);
    check("rst_sync_error", 64'(o_sync_error), 64'd0);
    check("rst_i_ready", 64'(i_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single pair, o_valid visible right after the R accept, for one cycle
    v0 = valid_cycles;
    push(32'h11111111, 32'h22222222);
    send(1'b1, 32'h11111111);
    send(1'b0, 32'h22222222);
    idle();
    check("t1_latency_valid", 64'(o_valid), 64'd1);
    wait_cycles(3);
    check("t1_valid_cycles", 64'(valid_cycles - v0), 64'd1);
    drain();

    // Four pairs streamed at full rate
    ready_low   = 0;
    watch_ready = 1;
    for (int i = 0; i < 4; i++) begin
      push(32'hA0000000 + 32'(i), 32'hB0000000 + 32'(i));
      send(1'b1, 32'hA0000000 + 32'(i));
      send(1'b0, 32'hB0000000 + 32'(i));
    end
    idle();
    watch_ready = 0;
    check("t2_ready_never_low", 64'(ready_low), 64'd0);
    drain();

    // Output stall: next L accepted, R blocked, pair held
    o_ready = 1'b0;
    push(32'hC0000001, 32'hD0000001);
    push(32'hC0000002, 32'hD0000002);
    send(1'b1, 32'hC0000001);
    send(1'b0, 32'hD0000001);
    send(1'b1, 32'hC0000002);
    i_valid   = 1'b1;
    i_is_left = 1'b0;
    i_audio   = 32'hD0000002;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_stall_i_ready", 64'(i_ready), 64'd0);
      check("t3_hold_pair", {o_left, o_right}, {32'hC0000001, 32'hD0000001});
    end
    @(posedge clk);
    #1;
    o_ready = 1'b1;
    @(negedge clk);
    check("t3_release_i_ready", 64'(i_ready), 64'd1);
    @(posedge clk);
    #1;
    idle();
    check("t3_no_bubble", 64'(o_valid), 64'd1);
    check("t3_second_pair", {o_left, o_right}, {32'hC0000002, 32'hD0000002});
    drain();

    // Misalignment: R, L=A, L=B, R=C
    s0 = sync_seen;
    push(32'h0000000B, 32'h0000000C);
    send(1'b0, 32'h00000099);
    send(1'b1, 32'h0000000A);
    send(1'b1, 32'h0000000B);
    send(1'b0, 32'h0000000C);
    idle();
    wait_cycles(3);
    check("t4_sync_pulses", 64'(sync_seen - s0), 64'd2);
    drain();

    // Reset mid-pair discards the staged left
    send(1'b1, 32'h00000077);
    idle();
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    check("t5_rst_o_valid", 64'(o_valid), 64'd0);
    s0 = sync_seen;
    push(32'h00000005, 32'h00000006);
    send(1'b0, 32'h00000088);
    send(1'b1, 32'h00000005);
    send(1'b0, 32'h00000006);
    idle();
    wait_cycles(3);
    check("t5_sync_pulses", 64'(sync_seen - s0), 64'd1);
    drain();

`ifdef STEREO_AUDIO_DESERIALIZER_ERRCNT_EN
    // Saturating error count with a 2-bit counter
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    check("t6_count_reset", 64'(o_error_count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 32'h00000100 + 32'(i));
      idle();
      wait_cycles(2);
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      check("t6_error_count", 64'(o_error_count), 64'(exp_cnt));
    end
`endif

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
